// File: rtl/rgb2gray_frame_ctrl.sv
// ============================================================================
// Module   : rgb2gray_frame_ctrl
// Brief    : Frame sequencer feeding source RGB pixels to an rgb2gray datapath
//            and writing gray results back. Optional watchdog: define WDT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb2gray_frame_ctrl #(
  parameter int DATAWIDTH  = 8,
  parameter int IMG_W      = 512,
  parameter int IMG_H      = 512,
  parameter int ADDRW      = 18,
  parameter int SETTLE     = 3,
  parameter int WDT_CYCLES = 16
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 frame_start,
  input  logic                 abort,
  output logic                 src_rd_en,
  output logic [ADDRW-1:0]     src_addr,
  input  logic [DATAWIDTH-1:0] src_r,
  input  logic [DATAWIDTH-1:0] src_g,
  input  logic [DATAWIDTH-1:0] src_b,
  output logic                 dp_start,
  output logic [DATAWIDTH-1:0] dp_r,
  output logic [DATAWIDTH-1:0] dp_g,
  output logic [DATAWIDTH-1:0] dp_b,
  input  logic [DATAWIDTH-1:0] dp_gray,
  input  logic                 dp_done,
  output logic                 dst_wr_en,
  output logic [ADDRW-1:0]     dst_addr,
  output logic [DATAWIDTH-1:0] dst_wdata,
  output logic                 busy,
  output logic                 frame_done,
  output logic [ADDRW-1:0]     pix_count,
  output logic                 err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_LAT  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_NEXT = 3'd5;

  localparam int              CNT_MAX   = (WDT_CYCLES > SETTLE) ? WDT_CYCLES : SETTLE;
  localparam int              CNTW      = $clog2(CNT_MAX + 2);
  localparam logic [CNTW-1:0] SETTLE_C  = CNTW'(SETTLE);
  localparam logic [CNTW-1:0] CNT_SAT   = CNTW'(CNT_MAX);
  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(IMG_W * IMG_H - 1);

  logic [2:0]           state_q, state_d;
  logic [ADDRW-1:0]     addr_q, addr_d;
  logic [ADDRW-1:0]     pix_q, pix_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 fdone_q, fdone_d;
  logic                 err_q, err_d;
  logic [DATAWIDTH-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [DATAWIDTH-1:0] wdata_q, wdata_d;
  logic                 accept;
  logic                 wdt_trip;

  // Early dp_done pulses belong to a previous pixel and are discarded.
  assign accept = (state_q == S_WAIT) && dp_done && (cnt_q >= SETTLE_C);

`ifdef WDT_EN
  localparam logic [CNTW-1:0] WDT_C = CNTW'(WDT_CYCLES);
  assign wdt_trip = (state_q == S_WAIT) && !accept && (cnt_q == WDT_C);
`else
  assign wdt_trip = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      pix_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      fdone_q <= 1'b0;
      err_q   <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pix_q   <= pix_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      fdone_q <= fdone_d;
      err_q   <= err_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pix_d   = pix_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    fdone_d = 1'b0;
    err_d   = err_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    wdata_d = wdata_q;
    if (state_q != S_IDLE && abort) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (frame_start && !abort) begin
            state_d = S_RD;
            addr_d  = '0;
            pix_d   = '0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
          end
        end
        S_RD: state_d = S_LAT;
        S_LAT: begin
          r_d     = src_r;
          g_d     = src_g;
          b_d     = src_b;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (accept) begin
            wdata_d = dp_gray;
            state_d = S_WR;
          end else if (wdt_trip) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WR: begin
          pix_d   = pix_q + 1'b1;
          state_d = S_NEXT;
        end
        S_NEXT: begin
          if (addr_q == LAST_ADDR) begin
            fdone_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_RD;
          end
        end
        default: begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // abort suppresses the write combinationally so no WR cycle can leak out.
  always_comb begin
    src_rd_en = (state_q == S_RD);
    dp_start  = (state_q == S_WAIT);
    dst_wr_en = (state_q == S_WR) && !abort;
  end

  assign src_addr   = addr_q;
  assign dst_addr   = addr_q;
  assign dp_r       = r_q;
  assign dp_g       = g_q;
  assign dp_b       = b_q;
  assign dst_wdata  = wdata_q;
  assign busy       = busy_q;
  assign frame_done = fdone_q;
  assign pix_count  = pix_q;
  assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_rgb2gray_frame_ctrl.sv
// ============================================================================
// Module   : tb_rgb2gray_frame_ctrl
// Brief    : Randomized self-checking bench with RAM, datapath stub and model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rgb2gray_frame_ctrl;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = W * H;
  localparam int AW = 18;
  localparam int SETTLE = 3;
  localparam int WDT = 16;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          frame_start = 1'b0;
  logic          abort = 1'b0;
  logic          src_rd_en;
  logic [AW-1:0] src_addr;
  logic [DW-1:0] src_r = '0, src_g = '0, src_b = '0;
  logic          dp_start;
  logic [DW-1:0] dp_r, dp_g, dp_b;
  logic [DW-1:0] dp_gray = '0;
  logic          dp_done = 1'b0;
  logic          dst_wr_en;
  logic [AW-1:0] dst_addr;
  logic [DW-1:0] dst_wdata;
  logic          busy, frame_done, err;
  logic [AW-1:0] pix_count;

  always #5 CLK = ~CLK;

  rgb2gray_frame_ctrl #(
    .DATAWIDTH(DW), .IMG_W(W), .IMG_H(H), .ADDRW(AW),
    .SETTLE(SETTLE), .WDT_CYCLES(WDT)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .frame_start(frame_start), .abort(abort),
    .src_rd_en(src_rd_en), .src_addr(src_addr),
    .src_r(src_r), .src_g(src_g), .src_b(src_b),
    .dp_start(dp_start), .dp_r(dp_r), .dp_g(dp_g), .dp_b(dp_b),
    .dp_gray(dp_gray), .dp_done(dp_done),
    .dst_wr_en(dst_wr_en), .dst_addr(dst_addr), .dst_wdata(dst_wdata),
    .busy(busy), .frame_done(frame_done), .pix_count(pix_count), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic [23:0] src_mem [N];
  logic [7:0]  dst_mem [N];
  int mode = 0;      // 0 random datapath, 1 scripted pulses, 2 silent
  int exp_idx = 0;
  int wr_count = 0;
  int fd_count = 0;

  // Reference datapath: gray = (76R + 150G + 29B) / 256
  function automatic logic [7:0] gray_of(input logic [23:0] p);
    int s;
    s = 76 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0]);
    return 8'(s >> 8);
  endfunction

  // Source RAM (1-cycle read latency) and datapath stub
  initial begin
    int wcnt;
    bit rd_prev;
    logic [AW-1:0] a_prev;
    wcnt = -1;
    rd_prev = 1'b0;
    a_prev = '0;
    forever begin
      @(negedge CLK);
      if (rd_prev && a_prev < AW'(N)) {src_r, src_g, src_b} = src_mem[a_prev];
      else {src_r, src_g, src_b} = 24'($urandom);
      rd_prev = src_rd_en;
      a_prev  = src_addr;
      wcnt    = dp_start ? wcnt + 1 : -1;
      dp_done = 1'b0;
      dp_gray = 8'($urandom);
      case (mode)
        0: if ($urandom_range(0, 3) == 0 || wcnt >= SETTLE + 6) begin
             dp_done = 1'b1;
             if (wcnt >= SETTLE && exp_idx < N) dp_gray = gray_of(src_mem[exp_idx]);
           end
        1: if (wcnt == 1) begin
             dp_done = 1'b1; dp_gray = 8'h55;
           end else if (wcnt == 4) begin
             dp_done = 1'b1; dp_gray = 8'hAA;
           end
        default: ;
      endcase
    end
  end

  // Destination RAM and scoreboard
  initial begin
    logic [7:0] ew;
    forever begin
      @(negedge CLK);
      #1;
      if (RSTn) begin
        if (dst_wr_en) begin
          chk("wr_addr", 32'(dst_addr), 32'(exp_idx));
          ew = (mode == 1) ? 8'hAA : ((exp_idx < N) ? gray_of(src_mem[exp_idx]) : 8'h00);
          chk("wr_data", 32'(dst_wdata), 32'(ew));
          if (exp_idx < N) dst_mem[exp_idx] = dst_wdata;
          exp_idx++;
          wr_count++;
        end
        if (dp_start && exp_idx < N) chk("dp_hold", 32'({dp_r, dp_g, dp_b}), 32'(src_mem[exp_idx]));
        if (frame_done) begin
          fd_count++;
          chk("busy_at_done", 32'(busy), 32'd0);
        end
      end
    end
  end

  task automatic start_frame();
    @(negedge CLK);
    exp_idx = 0;
    wr_count = 0;
    for (int i = 0; i < N; i++) dst_mem[i] = 8'hEE;
    frame_start = 1'b1;
    @(negedge CLK);
    frame_start = 1'b0;
  endtask

  task automatic wait_frame(input int f0);
    for (int i = 0; i < 600 && fd_count == f0; i++) @(negedge CLK);
    chk("frame_done_seen", 32'(fd_count - f0), 32'd1);
    repeat (3) @(negedge CLK);
    #2;
    chk("one_frame_done", 32'(fd_count - f0), 32'd1);
    chk("writes", 32'(wr_count), 32'(N));
    chk("pix_count", 32'(pix_count), 32'(N));
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic run_frame();
    int f0;
    f0 = fd_count;
    start_frame();
    wait_frame(f0);
  endtask

  task automatic wait_pixel_wait(input int idx);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 600 && !hit; i++) begin
      @(negedge CLK);
      #2;
      hit = dp_start && exp_idx == idx;
    end
    chk("reach_pixel", 32'(hit), 32'd1);
  endtask

  initial begin
    int f0;
    for (int i = 0; i < N; i++) src_mem[i] = '0;
    repeat (3) @(negedge CLK);
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_rd_en", 32'(src_rd_en), 0);
    chk("rst_wr_en", 32'(dst_wr_en), 0);
    chk("rst_dp_start", 32'(dp_start), 0);
    chk("rst_addrs", 32'({src_addr, dst_addr}), 0);
    chk("rst_data", 32'({dp_r, dp_g, dp_b, dst_wdata}), 0);
    chk("rst_pix_err", 32'({pix_count, err}), 0);
    RSTn = 1'b1;

    // All-white frame
    for (int i = 0; i < N; i++) src_mem[i] = 24'hFFFFFF;
    run_frame();
    for (int i = 0; i < N; i++) chk("white_dst", 32'(dst_mem[i]), 32'd254);

    // Single red pixel at address 3
    for (int i = 0; i < N; i++) src_mem[i] = '0;
    src_mem[3] = {8'd100, 8'd0, 8'd0};
    run_frame();
    for (int i = 0; i < N; i++) chk("red_dst", 32'(dst_mem[i]), (i == 3) ? 32'd29 : 32'd0);

    // Random frames with random datapath timing
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) src_mem[i] = 24'($urandom);
      run_frame();
      for (int i = 0; i < N; i++) chk("rand_dst", 32'(dst_mem[i]), 32'(gray_of(src_mem[i])));
    end

    // Stale pulse at cnt=1 ignored, pulse at cnt=4 taken
    mode = 1;
    run_frame();
    for (int i = 0; i < N; i++) chk("stale_dst", 32'(dst_mem[i]), 32'hAA);
    mode = 0;

    // Abort during WAIT of pixel 5
    for (int i = 0; i < N; i++) src_mem[i] = 24'($urandom);
    f0 = fd_count;
    start_frame();
    wait_pixel_wait(5);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    #2;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_pix", 32'(pix_count), 5);
    chk("abort_nowr5", 32'(exp_idx), 5);
    repeat (4) @(negedge CLK);
    #2;
    chk("abort_stays_idle", 32'({busy, src_rd_en, dp_start}), 0);
    chk("abort_no_done", 32'(fd_count - f0), 0);
    run_frame();

    // frame_start while busy is ignored
    f0 = fd_count;
    start_frame();
    wait_pixel_wait(3);
    frame_start = 1'b1;
    @(negedge CLK);
    frame_start = 1'b0;
    wait_frame(f0);

    // abort and frame_start together in IDLE
    f0 = fd_count;
    @(negedge CLK);
    abort = 1'b1;
    frame_start = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    frame_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("abort_start_idle", 32'({busy, src_rd_en}), 0);
      @(negedge CLK);
    end
    chk("abort_start_nodone", 32'(fd_count - f0), 0);

`ifdef WDT_EN
    begin
      int wait_cycles;
      mode = 2;
      f0 = fd_count;
      start_frame();
      wait_cycles = 0;
      for (int i = 0; i < 200 && busy; i++) begin
        #2;
        if (dp_start) wait_cycles++;
        @(negedge CLK);
      end
      #2;
      chk("wdt_busy", 32'(busy), 0);
      chk("wdt_err", 32'(err), 1);
      chk("wdt_window", 32'(wait_cycles), 32'(WDT + 1));
      chk("wdt_nowrite", 32'(wr_count), 0);
      chk("wdt_nodone", 32'(fd_count - f0), 0);
      mode = 0;
      f0 = fd_count;
      start_frame();
      #2;
      chk("wdt_err_clear", 32'(err), 0);
      wait_frame(f0);
    end
`else
    chk("err_tied", 32'(err), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
